// File: rtl/booth_divider_seq.sv
// booth_divider_seq: sequential signed restoring divider, WIDTH steps per operation, start/busy/done handshake
// ports: clk, rst_n (async active-low), start, dividend, divisor -> busy, done (1-cycle pulse), quotient, remainder, div_by_zero, overflow
module booth_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] p, qm, dvs, a_q, a_mag, b_mag;
  logic sign_q, sign_r, dz, ov;
  logic [WIDTH:0] p_sh, diff;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  // partial remainder stays below |divisor| <= 2^(WIDTH-1), so the shifted value fits WIDTH+1 bits
  // and the trial subtraction's top bit is a clean borrow
  assign p_sh = {p, qm[WIDTH-1]};
  assign diff = p_sh - {1'b0, dvs};
  assign busy = state != IDLE;
  assign done = state == FIX;
  // CALC lingers one cycle with cnt==0 while the signed results are formed
  always_comb state_d = state == IDLE ? (start ? CALC : IDLE) :
                        state == CALC ? (cnt == '0 ? FIX : CALC) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      p <= '0;
      qm <= '0;
      dvs <= '0;
      a_q <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= CW'(WIDTH);
      p <= '0;
      qm <= a_mag;
      dvs <= b_mag;
      a_q <= dividend;
      sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r <= dividend[WIDTH-1];
      dz <= divisor == '0;
      ov <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (state == CALC && cnt != '0) begin
      p <= diff[WIDTH] ? p_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      qm <= {qm[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt - CW'(1);
    end else if (state == CALC) begin
      quotient <= dz ? '1 : sign_q ? -qm : qm;
      remainder <= dz ? a_q : sign_r ? -p : p;
      div_by_zero <= dz;
      overflow <= ov;
    end
  end
endmodule

// File: tb/tb_booth_divider_seq.sv
// tb_booth_divider_seq: randomized/exhaustive check of booth_divider_seq against an arithmetic reference model
module tb_booth_divider_seq;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;
  int n_vec = 0, n_err = 0;

  booth_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer division truncating toward zero, wrapped to W bits
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dz = bi == 0;
    ov = ai == -(1 << (W - 1)) && bi == -1;
    qi = dz ? -1 : ai / bi;
    ri = dz ? ai : ai % bi;
    q = qi[W-1:0];
    r = ri[W-1:0];
  endfunction

  // one operation; optional second start pulse with junk operands at cycle 2 must be ignored
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [W-1:0] eq, er;
    logic edz, eov;
    int cyc;
    model(a, b, eq, er, edz, eov);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      if (inject && cyc == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk($sformatf("latency %0d/%0d", $signed(a), $signed(b)), cyc, W + 1);
    chk($sformatf("quotient %0d/%0d", $signed(a), $signed(b)), quotient, eq);
    chk($sformatf("remainder %0d/%0d", $signed(a), $signed(b)), remainder, er);
    chk($sformatf("flags %0d/%0d", $signed(a), $signed(b)), {div_by_zero, overflow}, {edz, eov});
    chk("busy_at_done", busy, 1);
    @(posedge clk); #1;
    chk("done_pulse_width", {done, busy}, 0);
    chk("quotient_hold", quotient, eq);
  endtask

  initial begin
    int cyc;
    #1;
    chk("reset_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(4'd7, 4'd2, 0);
    run(4'b1001, 4'd2, 0);
    run(4'd7, 4'b1110, 0);
    run(4'b1001, 4'b1110, 0);
    run(4'b1000, 4'b1111, 0);
    run(4'd5, 4'd0, 0);
    run(4'd6, 4'd3, 1);
    chk("ignored_start_q", quotient, 2);
    chk("ignored_start_r", remainder, 0);
    // reset in the middle of an operation
    start = 1'b1;
    dividend = 4'd5;
    divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    chk("no_done_after_abort", cyc, 0);
    run(4'd7, 4'd2, 0);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run(W'(i), W'(j), 0);
    repeat (60) run(W'($urandom), W'($urandom), $urandom_range(0, 1) == 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
